led_nios_sysid_checker: RTL

//  Avalon-MM read master for the system-ID slave. On a start request it reads
//  the ID word (address 0), then the timestamp word (address 1), and compares

---
 rtl/led_nios_sysid_checker.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/led_nios_sysid_checker.sv
// rtl/led_nios_sysid_checker.sv - Avalon-MM system-ID read-and-compare checker (SYSID_CHECK_TS_EN enables the timestamp read)
module led_nios_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS    = 32'h5F17_8F7B,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

`ifdef SYSID_CHECK_TS_EN
    typedef enum logic [1:0] {S_IDLE, S_RD_ID, S_RD_TS, S_FIN} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_RD_ID, S_FIN} state_t;
`endif

    localparam logic [7:0] STALL_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  stall_q, stall_d;
    logic        id_ok_q, id_ok_d;
    logic        timeout_q, timeout_d;
    logic [31:0] id_value_q, id_value_d;
    logic        accept;
    logic        expire;

`ifdef SYSID_CHECK_TS_EN
    logic        ts_ok_q, ts_ok_d;
    logic [31:0] ts_value_q, ts_value_d;
    assign avm_read    = (state_q == S_RD_ID) || (state_q == S_RD_TS);
    assign avm_address = (state_q == S_RD_TS);
`else
    assign avm_read    = (state_q == S_RD_ID);
    assign avm_address = 1'b0;
`endif

    assign accept = avm_read && !avm_waitrequest;
    // The abandoning edge is the one on which the stall count would reach the limit.
    assign expire = avm_read && avm_waitrequest && (stall_q == STALL_LAST);

    always_comb begin
        state_d    = state_q;
        stall_d    = stall_q;
        id_ok_d    = id_ok_q;
        timeout_d  = timeout_q;
        id_value_d = id_value_q;
`ifdef SYSID_CHECK_TS_EN
        ts_ok_d    = ts_ok_q;
        ts_value_d = ts_value_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_RD_ID;
                    stall_d    = 8'd0;
                    id_ok_d    = 1'b0;
                    timeout_d  = 1'b0;
                    id_value_d = 32'd0;
`ifdef SYSID_CHECK_TS_EN
                    ts_ok_d    = 1'b0;
                    ts_value_d = 32'd0;
`endif
                end
            end
            S_RD_ID: begin
                if (accept) begin
                    id_value_d = avm_readdata;
                    id_ok_d    = (avm_readdata == EXPECTED_ID);
                    stall_d    = 8'd0;
`ifdef SYSID_CHECK_TS_EN
                    state_d    = S_RD_TS;
`else
                    state_d    = S_FIN;
`endif
                end else if (expire) begin
                    timeout_d = 1'b1;
                    state_d   = S_FIN;
                end else begin
                    stall_d = stall_q + 8'd1;
                end
            end
`ifdef SYSID_CHECK_TS_EN
            S_RD_TS: begin
                if (accept) begin
                    ts_value_d = avm_readdata;
                    ts_ok_d    = (avm_readdata == EXPECTED_TS);
                    state_d    = S_FIN;
                end else if (expire) begin
                    timeout_d = 1'b1;
                    state_d   = S_FIN;
                end else begin
                    stall_d = stall_q + 8'd1;
                end
            end
`endif
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            stall_q    <= 8'd0;
            id_ok_q    <= 1'b0;
            timeout_q  <= 1'b0;
            id_value_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            stall_q    <= stall_d;
            id_ok_q    <= id_ok_d;
            timeout_q  <= timeout_d;
            id_value_q <= id_value_d;
        end
    end

`ifdef SYSID_CHECK_TS_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ts_ok_q    <= 1'b0;
            ts_value_q <= 32'd0;
        end else begin
            ts_ok_q    <= ts_ok_d;
            ts_value_q <= ts_value_d;
        end
    end

    assign ts_ok    = ts_ok_q;
    assign ts_value = ts_value_q;
`else
    assign ts_ok    = 1'b1;
    assign ts_value = 32'd0;
`endif

    assign busy     = avm_read;
    assign done     = (state_q == S_FIN);
    assign id_ok    = id_ok_q;
    assign timeout  = timeout_q;
    assign id_value = id_value_q;

endmodule
